sync_fifo_reader: RTL
=====================

# sync_fifo_reader

Read-side adapter for `sync_fifo`. It drains the FIFO's registered read port (`read_en` / `empty` / `data_out`, one-cycle read latency) and presents the words as a valid/ready stream to the downstream consumer. It sits between the FIFO and any stream sink. A 2-entry output buffer sustains one word per cycle under continuous `m_ready` and absorbs backpressure without losing in-flight reads.

## Interface

- `WIDTH`, default 16: data word width; must match the attached FIFO.
- `clk`  input  1  rising-edge clock, shared with the FIFO.
- `rst_n`  input  1  asynchronous active-low reset.
- `fifo_empty`  input  1  FIFO `empty` flag.
- `fifo_rdata`  input  WIDTH  FIFO `data_out`; valid the cycle after `fifo_read_en` was high.
- `fifo_read_en`  output  1  FIFO `read_en`; combinational.
- `m_valid`  output  1  a word is presented on `m_data`.
- `m_ready`  input  1  consumer accepts the word.
- `m_data`  output  WIDTH  head word; registered.
- `rd_count`  output  32  words delivered; present only with `SYNC_FIFO_RD_CNT_EN`.

## Operation

- State `occ` ∈ {EMPTY=0, ONE=1, TWO=2}: buffer occupancy. `inflight` flag: a FIFO read was issued last cycle.
- `pop` = `m_valid && m_ready`.
- `fifo_read_en` = `!fifo_empty && (occ + inflight - pop) < 2`. This never over-commits buffer space.
- When `inflight` is set, `fifo_rdata` is written into slot index `occ - pop` at the clock edge.
- `pop` shifts slot1 into slot0.
- Next `occ` = `occ + inflight - pop`. Arithmetic uses 2-bit unsigned; the result never exceeds 2 and never underflows.
- Transitions:
  - EMPTY→ONE on arrival.
  - ONE→TWO on arrival without pop.
  - ONE→EMPTY on pop without arrival.
  - TWO→ONE on pop without arrival.
  - Arrival together with pop keeps the state.
- `m_valid` = (`occ != EMPTY`). `m_data` = slot0.
- Once `m_valid` is high, `m_data` and `m_valid` stay stable until `pop` (AXI-style rule).
- The `fifo_empty` sample is used as-is. The FIFO ignores reads while empty, but the adapter never issues one.

## Timing

- Reset state: `occ`=EMPTY, `inflight`=0, `m_valid`=0, `m_data`=0, `rd_count`=0, slots=0. `fifo_read_en` is 0 while in reset.
- Latency: `fifo_empty` falls in cycle N with the adapter EMPTY → `fifo_read_en` high in N → data on `fifo_rdata` in N+1 → `m_valid` high in N+2.
- Throughput: 1 word/cycle in steady state (`occ`=ONE, `inflight`=1, `pop` every cycle).
- Backpressure: with `m_ready` low, at most one further read completes; `occ` reaches TWO and `fifo_read_en` stays low.
- FIFO drained mid-stream: buffered words are still delivered, then `m_valid` falls the cycle after the last `pop`.
- Reset mid-operation: buffered and in-flight words are discarded and all outputs return to reset values immediately. The FIFO shares `rst_n`, so both sides restart empty.

## Configuration

- `SYNC_FIFO_RD_CNT_EN` defined: `rd_count` port exists.
  - It increments by 1 on each `pop`.
  - It wraps from 0xFFFFFFFF to 0.
  - It is reset to 0.
- Not defined: no `rd_count` port and no counter logic. Stream behaviour is identical.

## Structure

- Shared package `sync_fifo_pkg` holds:
  - occupancy state enum `occ_t` {OCC_EMPTY, OCC_ONE, OCC_TWO};
  - constant `RD_LATENCY = 1`;
  - constant `BUF_DEPTH = 2`.
- One sub-module, `fifo_rd_skid`: the 2-slot buffer with occupancy state, slot write/shift and `m_valid`/`m_data`.
- The top level holds the issue logic, the `inflight` flag and the optional counter.

## Test plan

- Single word: FIFO writes 0x1234 once, `m_ready`=1 → exactly one `m_valid` cycle with `m_data`=0x1234, two cycles after `fifo_empty` falls.
- Burst: FIFO preloaded with 0x0001..0x0010, `m_ready`=1 → 16 consecutive `m_valid` cycles in order, no gaps, then `m_valid`=0.
- Backpressure: 8 words preloaded, `m_ready` low for 5 cycles then high → `occ` stops at TWO, `fifo_read_en` low while stalled, `m_data` held at 0x0001, all 8 words delivered in order.
- Random `m_ready` (50%) with concurrent FIFO writes of an incrementing pattern, 1000 words → no loss, no duplication, in-order; `fifo_read_en` never high while `fifo_empty`=1.
- Reset mid-burst: assert `rst_n`=0 while `occ`=TWO and `inflight`=1 → `m_valid`=0, `m_data`=0 immediately; after release, new word 0xBEEF delivered first.
- With `SYNC_FIFO_RD_CNT_EN`: after the 16-word burst, `rd_count`=16. Force the counter to 0xFFFFFFFF, pop one word → `rd_count`=0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared occupancy type and constants for the sync_fifo read adapter
// Contents: occ_t (read buffer occupancy), RD_LATENCY (FIFO read latency),
//           BUF_DEPTH (read buffer slots).
package sync_fifo_pkg;
    typedef enum logic [1:0] {OCC_EMPTY = 2'd0, OCC_ONE = 2'd1, OCC_TWO = 2'd2} occ_t;
    localparam int RD_LATENCY = 1;
    localparam int BUF_DEPTH  = 2;
endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-slot output buffer turning registered FIFO reads into a valid/ready stream
// Ports: clk, rst_n (async active-low); wr_en/wr_data = FIFO word arriving this cycle;
//        m_valid/m_ready/m_data = downstream stream; occ_next = occupancy after this edge.
module fifo_rd_skid
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             m_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       occ_next
);
    occ_t             occ_q;
    logic [WIDTH-1:0] slot0, slot1;
    logic             pop;
    logic [1:0]       idx;

    assign m_valid  = occ_q != OCC_EMPTY;
    assign m_data   = slot0;
    assign pop      = m_valid && m_ready;
    assign occ_next = occ_q + {1'b0, wr_en} - {1'b0, pop};
    // Arriving word lands behind whatever survives this edge's pop.
    assign idx      = occ_q - {1'b0, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= OCC_EMPTY;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            occ_q <= occ_t'(occ_next);
            slot0 <= (wr_en && idx == 2'd0) ? wr_data : pop ? slot1 : slot0;
            slot1 <= (wr_en && idx == 2'd1) ? wr_data : slot1;
        end
    end
endmodule

// File: rtl/sync_fifo_reader.sv
// sync_fifo_reader: drains a sync_fifo registered read port into a valid/ready stream
// Ports: clk, rst_n (async active-low); fifo_empty/fifo_rdata/fifo_read_en = FIFO read side;
//        m_valid/m_ready/m_data = downstream stream;
//        rd_count = delivered-word counter, present only when SYNC_FIFO_RD_CNT_EN is defined.
module sync_fifo_reader
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_read_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
`ifdef SYNC_FIFO_RD_CNT_EN
    ,
    output logic [31:0]      rd_count
`endif
);
    logic       inflight;
    logic [1:0] occ_next;

    fifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (inflight),
        .wr_data (fifo_rdata),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .occ_next(occ_next)
    );

    // Issue only if the word can still fit once it lands; rst_n gates it so no read leaks out during reset.
    assign fifo_read_en = rst_n && !fifo_empty && occ_next < 2'(BUF_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight <= 1'b0;
        else        inflight <= fifo_read_en;
    end

`ifdef SYNC_FIFO_RD_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  rd_count <= '0;
        else if (m_valid && m_ready) rd_count <= rd_count + 32'd1;
    end
`endif
endmodule
